alu_rs: RTL and testbench

- N-entry reservation station feeding the single scalar_alu.
- Accepts dispatched ALU/branch-compare ops with operand values or ROB dependency tags.
- Snoops both CDBs (ALU result bus, memory result bus) to wake operands; each cycle it issues at most one fully-ready entry to the ALU.
- Sits between decoder/dispatch and scalar_alu; cleared by ROB flush on mispredict.

---
 rtl/alu_rs_pkg.sv | 59 +++++
 rtl/alu_rs_if.sv | 47 ++++
 rtl/alu_rs_select.sv | 40 ++++
 rtl/alu_rs.sv | 151 +++++++++++++++
 tb/tb_alu_rs.sv | 531 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rs_pkg.sv
// Shared types and constants for the ALU reservation station.
// The snoop helper resolves one operand against both result buses.
package alu_rs_pkg;

    localparam int RS_SIZE_BIT = 3;
    localparam int RS_SIZE     = 1 << RS_SIZE_BIT;
    localparam int ROB_W       = 4;
    localparam int TYPE_W      = 5;

    typedef struct packed {
        logic              busy;
        logic [TYPE_W-1:0] op_type;
        logic [31:0]       v1;
        logic [31:0]       v2;
        logic              has_dep1;
        logic              has_dep2;
        logic [ROB_W-1:0]  dep1;
        logic [ROB_W-1:0]  dep2;
        logic [ROB_W-1:0]  rob_id;
    } rs_entry_t;

    typedef struct packed {
        logic [TYPE_W-1:0] op_type;
        logic [31:0]       v1;
        logic [31:0]       v2;
        logic [ROB_W-1:0]  rob_id;
    } issue_t;

    typedef struct packed {
        logic        has_dep;
        logic [31:0] value;
    } operand_t;

    // The ALU bus is checked first so it wins if both buses carry the same tag.
    function automatic operand_t snoop_operand(
        input logic             has_dep,
        input logic [ROB_W-1:0] dep,
        input logic [31:0]      value,
        input logic             alu_rdy,
        input logic [ROB_W-1:0] alu_tag,
        input logic [31:0]      alu_val,
        input logic             mem_rdy,
        input logic [ROB_W-1:0] mem_tag,
        input logic [31:0]      mem_val
    );
        operand_t res;
        res.has_dep = has_dep;
        res.value   = value;
        if (has_dep && alu_rdy && (alu_tag == dep)) begin
            res.has_dep = 1'b0;
            res.value   = alu_val;
        end else if (has_dep && mem_rdy && (mem_tag == dep)) begin
            res.has_dep = 1'b0;
            res.value   = mem_val;
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Dispatch, CDB snoop and ALU issue signals of the ALU reservation station.
// master = dispatcher/CDB/ALU side, slave = the reservation station.
interface alu_rs_if;
    import alu_rs_pkg::*;

    logic              inst_valid;
    logic [TYPE_W-1:0] inst_type;
    logic [31:0]       inst_r1;
    logic [31:0]       inst_r2;
    logic              inst_has_dep1;
    logic              inst_has_dep2;
    logic [ROB_W-1:0]  inst_dep1;
    logic [ROB_W-1:0]  inst_dep2;
    logic [ROB_W-1:0]  inst_rob_id;
    logic              full;
    logic              dispatch_err;

    logic              cdb_alu_ready;
    logic [ROB_W-1:0]  cdb_alu_rob_id;
    logic [31:0]       cdb_alu_value;
    logic              cdb_mem_ready;
    logic [ROB_W-1:0]  cdb_mem_rob_id;
    logic [31:0]       cdb_mem_value;

    logic              alu_valid;
    logic [TYPE_W-1:0] alu_type;
    logic [31:0]       alu_r1;
    logic [31:0]       alu_r2;
    logic [ROB_W-1:0]  alu_rob_id;

    modport master (
        output inst_valid, inst_type, inst_r1, inst_r2, inst_has_dep1, inst_has_dep2,
               inst_dep1, inst_dep2, inst_rob_id,
               cdb_alu_ready, cdb_alu_rob_id, cdb_alu_value,
               cdb_mem_ready, cdb_mem_rob_id, cdb_mem_value,
        input  full, dispatch_err, alu_valid, alu_type, alu_r1, alu_r2, alu_rob_id
    );

    modport slave (
        input  inst_valid, inst_type, inst_r1, inst_r2, inst_has_dep1, inst_has_dep2,
               inst_dep1, inst_dep2, inst_rob_id,
               cdb_alu_ready, cdb_alu_rob_id, cdb_alu_value,
               cdb_mem_ready, cdb_mem_rob_id, cdb_mem_value,
        output full, dispatch_err, alu_valid, alu_type, alu_r1, alu_r2, alu_rob_id
    );

endinterface

// File: rtl/alu_rs_select.sv
// One-of-N picker: lowest index wins, or with USE_AGE the request with no older
// request wins (age[i][j] = 1 means entry j is older than entry i).
module alu_rs_select
    import alu_rs_pkg::*;
#(
    parameter bit USE_AGE = 1'b0
) (
    input  logic [RS_SIZE-1:0]              req,
    input  logic [RS_SIZE-1:0][RS_SIZE-1:0] age,
    output logic                            found,
    output logic [RS_SIZE_BIT-1:0]          idx
);

    logic [RS_SIZE-1:0] grant;

    genvar gi;
    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_grant
            if (USE_AGE) begin : g_age
                assign grant[gi] = req[gi] & ~(|(req & age[gi]));
            end else begin : g_fixed
                assign grant[gi] = req[gi] & ~(|(req & ((RS_SIZE'(1) << gi) - RS_SIZE'(1))));
            end
        end
        if (!USE_AGE) begin : g_no_age
            logic unused_age;
            assign unused_age = ^age;
        end
    endgenerate

    always_comb begin
        idx = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (grant[i]) idx = idx | RS_SIZE_BIT'(i);
        end
    end

    assign found = |req;

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: dispatch with CDB bypass, operand wakeup, one issue per cycle.
// Define AGE_PRIORITY_EN for oldest-ready-first issue; otherwise lowest index wins.
module alu_rs
    import alu_rs_pkg::*;
(
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     flush,
    alu_rs_if.slave  rs
);

    logic [RS_SIZE-1:0]              busy_vec;
    logic [RS_SIZE-1:0]              ready_vec;
    issue_t [RS_SIZE-1:0]            issue_view;
    logic [RS_SIZE-1:0][RS_SIZE-1:0] age_mat;

    logic                   free_found;
    logic [RS_SIZE_BIT-1:0] free_idx;
    logic                   issue_found;
    logic [RS_SIZE_BIT-1:0] issue_idx;
    logic                   do_dispatch;
    operand_t               disp1;
    operand_t               disp2;
    rs_entry_t              new_entry;

    assign rs.full     = &busy_vec;
    assign do_dispatch = rdy_in && !flush && rs.inst_valid && !rs.full;

    assign disp1 = snoop_operand(rs.inst_has_dep1, rs.inst_dep1, rs.inst_r1,
                                 rs.cdb_alu_ready, rs.cdb_alu_rob_id, rs.cdb_alu_value,
                                 rs.cdb_mem_ready, rs.cdb_mem_rob_id, rs.cdb_mem_value);
    assign disp2 = snoop_operand(rs.inst_has_dep2, rs.inst_dep2, rs.inst_r2,
                                 rs.cdb_alu_ready, rs.cdb_alu_rob_id, rs.cdb_alu_value,
                                 rs.cdb_mem_ready, rs.cdb_mem_rob_id, rs.cdb_mem_value);

    assign new_entry = '{busy:     1'b1,
                         op_type:  rs.inst_type,
                         v1:       disp1.value,
                         v2:       disp2.value,
                         has_dep1: disp1.has_dep,
                         has_dep2: disp2.has_dep,
                         dep1:     rs.inst_dep1,
                         dep2:     rs.inst_dep2,
                         rob_id:   rs.inst_rob_id};

`ifdef AGE_PRIORITY_EN
    localparam bit USE_AGE = 1'b1;
    logic [RS_SIZE-1:0][RS_SIZE-1:0] age_reg;

    // A new entry is younger than everything busy; clearing its column drops stale
    // "older than" claims left by the previous occupant of the slot.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            age_reg <= '0;
        end else if (do_dispatch) begin
            for (int k = 0; k < RS_SIZE; k++) begin
                age_reg[k][free_idx] <= 1'b0;
            end
            age_reg[free_idx] <= busy_vec;
        end
    end
    assign age_mat = age_reg;
`else
    localparam bit USE_AGE = 1'b0;
    assign age_mat = '0;
`endif

    alu_rs_select #(.USE_AGE(1'b0)) u_free_sel (
        .req   (~busy_vec),
        .age   ('0),
        .found (free_found),
        .idx   (free_idx)
    );

    alu_rs_select #(.USE_AGE(USE_AGE)) u_issue_sel (
        .req   (ready_vec),
        .age   (age_mat),
        .found (issue_found),
        .idx   (issue_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_ent
            rs_entry_t ent_reg;
            operand_t  wake1;
            operand_t  wake2;
            logic      alloc_hit;
            logic      issue_hit;

            assign wake1 = snoop_operand(ent_reg.has_dep1, ent_reg.dep1, ent_reg.v1,
                                         rs.cdb_alu_ready, rs.cdb_alu_rob_id, rs.cdb_alu_value,
                                         rs.cdb_mem_ready, rs.cdb_mem_rob_id, rs.cdb_mem_value);
            assign wake2 = snoop_operand(ent_reg.has_dep2, ent_reg.dep2, ent_reg.v2,
                                         rs.cdb_alu_ready, rs.cdb_alu_rob_id, rs.cdb_alu_value,
                                         rs.cdb_mem_ready, rs.cdb_mem_rob_id, rs.cdb_mem_value);
            assign alloc_hit = do_dispatch && free_found && (free_idx == RS_SIZE_BIT'(gi));
            assign issue_hit = issue_found && (issue_idx == RS_SIZE_BIT'(gi));

            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    ent_reg <= '0;
                end else if (rdy_in) begin
                    if (flush) begin
                        ent_reg.busy <= 1'b0;
                    end else if (alloc_hit) begin
                        ent_reg <= new_entry;
                    end else if (ent_reg.busy) begin
                        ent_reg.has_dep1 <= wake1.has_dep;
                        ent_reg.v1       <= wake1.value;
                        ent_reg.has_dep2 <= wake2.has_dep;
                        ent_reg.v2       <= wake2.value;
                        if (issue_hit) ent_reg.busy <= 1'b0;
                    end
                end
            end

            assign busy_vec[gi]   = ent_reg.busy;
            assign ready_vec[gi]  = ent_reg.busy & ~ent_reg.has_dep1 & ~ent_reg.has_dep2;
            assign issue_view[gi] = '{op_type: ent_reg.op_type, v1: ent_reg.v1,
                                      v2: ent_reg.v2, rob_id: ent_reg.rob_id};
        end
    endgenerate

    // Issue register; a dispatch attempt while full is latched as a sticky error.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rs.alu_valid    <= 1'b0;
            rs.alu_type     <= '0;
            rs.alu_r1       <= '0;
            rs.alu_r2       <= '0;
            rs.alu_rob_id   <= '0;
            rs.dispatch_err <= 1'b0;
        end else if (rdy_in) begin
            if (rs.inst_valid && rs.full) rs.dispatch_err <= 1'b1;
            if (flush) begin
                rs.alu_valid <= 1'b0;
            end else if (issue_found) begin
                rs.alu_valid  <= 1'b1;
                rs.alu_type   <= issue_view[issue_idx].op_type;
                rs.alu_r1     <= issue_view[issue_idx].v1;
                rs.alu_r2     <= issue_view[issue_idx].v2;
                rs.alu_rob_id <= issue_view[issue_idx].rob_id;
            end else begin
                rs.alu_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus a randomized run against
// a scoreboard of outstanding ops keyed by ROB id.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    logic flush  = 1'b0;

    alu_rs_if bus();

    alu_rs dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .flush  (flush),
        .rs     (bus)
    );

    always #5 clk_in = ~clk_in;

    int tests_run    = 0;
    int tests_failed = 0;

    // scoreboard for the random run, indexed by ROB id
    bit          m_valid [16];
    logic [4:0]  m_type  [16];
    logic [31:0] m_v1    [16];
    logic [31:0] m_v2    [16];
    bit          m_hd1   [16];
    bit          m_hd2   [16];
    logic [3:0]  m_d1    [16];
    logic [3:0]  m_d2    [16];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [73:0] obs();
        return {bus.alu_valid, bus.alu_type, bus.alu_r1, bus.alu_r2, bus.alu_rob_id};
    endfunction

    function automatic logic [73:0] exp_issue(input logic [4:0] t, input logic [31:0] r1,
                                              input logic [31:0] r2, input logic [3:0] rob);
        return {1'b1, t, r1, r2, rob};
    endfunction

    task automatic idle();
        bus.inst_valid     = 1'b0;
        bus.inst_type      = '0;
        bus.inst_r1        = '0;
        bus.inst_r2        = '0;
        bus.inst_has_dep1  = 1'b0;
        bus.inst_has_dep2  = 1'b0;
        bus.inst_dep1      = '0;
        bus.inst_dep2      = '0;
        bus.inst_rob_id    = '0;
        bus.cdb_alu_ready  = 1'b0;
        bus.cdb_alu_rob_id = '0;
        bus.cdb_alu_value  = '0;
        bus.cdb_mem_ready  = 1'b0;
        bus.cdb_mem_rob_id = '0;
        bus.cdb_mem_value  = '0;
    endtask

    task automatic disp(input logic [4:0] t, input logic [31:0] r1, input logic [31:0] r2,
                        input logic hd1, input logic [3:0] d1,
                        input logic hd2, input logic [3:0] d2, input logic [3:0] rob);
        bus.inst_valid    = 1'b1;
        bus.inst_type     = t;
        bus.inst_r1       = r1;
        bus.inst_r2       = r2;
        bus.inst_has_dep1 = hd1;
        bus.inst_dep1     = d1;
        bus.inst_has_dep2 = hd2;
        bus.inst_dep2     = d2;
        bus.inst_rob_id   = rob;
    endtask

    task automatic do_reset();
        idle();
        rdy_in = 1'b1;
        flush  = 1'b0;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (obs() !== 74'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", obs());
        end
        tests_run++;
        if ({bus.full, bus.dispatch_err} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_full_err: got %b expected 00", {bus.full, bus.dispatch_err});
        end
        $display("[TB] reset done");
    endtask

    task automatic test_basic();
        disp(5'h00, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        tick();
        idle();
        tests_run++;
        if (bus.alu_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_early: alu_valid got %b expected 0", bus.alu_valid);
        end
        tick();
        tests_run++;
        if (obs() !== exp_issue(5'h00, 32'd5, 32'd7, 4'd3)) begin
            tests_failed++;
            $display("FAIL basic_issue: got %h expected %h", obs(), exp_issue(5'h00, 32'd5, 32'd7, 4'd3));
        end
        tick();
        tests_run++;
        if (bus.alu_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_single: alu_valid got %b expected 0", bus.alu_valid);
        end
        $display("[TB] basic add rob=3 issued");
    endtask

    task automatic test_wakeup();
        disp(5'h08, 32'hdead, 32'h22, 1'b1, 4'd6, 1'b0, 4'd0, 4'd5);
        tick();
        idle();
        for (int c = 0; c < 2; c++) begin
            tick();
            tests_run++;
            if (bus.alu_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL wakeup_blocked: cycle %0d alu_valid got %b expected 0", c, bus.alu_valid);
            end
        end
        bus.cdb_mem_ready  = 1'b1;
        bus.cdb_mem_rob_id = 4'd6;
        bus.cdb_mem_value  = 32'h10;
        tick();
        idle();
        tests_run++;
        if (bus.alu_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wakeup_same_cycle: alu_valid got %b expected 0", bus.alu_valid);
        end
        tick();
        tests_run++;
        if (obs() !== exp_issue(5'h08, 32'h10, 32'h22, 4'd5)) begin
            tests_failed++;
            $display("FAIL wakeup_issue: got %h expected %h", obs(), exp_issue(5'h08, 32'h10, 32'h22, 4'd5));
        end
        $display("[TB] sub rob=5 woken by mem bus");
    endtask

    task automatic test_bypass();
        // both buses carry tag 2; the ALU bus value must win
        disp(5'h00, 32'd4, 32'hffff, 1'b0, 4'd0, 1'b1, 4'd2, 4'd7);
        bus.cdb_alu_ready  = 1'b1;
        bus.cdb_alu_rob_id = 4'd2;
        bus.cdb_alu_value  = 32'd9;
        bus.cdb_mem_ready  = 1'b1;
        bus.cdb_mem_rob_id = 4'd2;
        bus.cdb_mem_value  = 32'h77;
        tick();
        idle();
        tests_run++;
        if (bus.alu_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bypass_early: alu_valid got %b expected 0", bus.alu_valid);
        end
        tick();
        tests_run++;
        if (obs() !== exp_issue(5'h00, 32'd4, 32'd9, 4'd7)) begin
            tests_failed++;
            $display("FAIL bypass_issue: got %h expected %h", obs(), exp_issue(5'h00, 32'd4, 32'd9, 4'd7));
        end
        $display("[TB] bypass rob=7 issued");
    endtask

    task automatic test_full();
        logic [31:0] r2s [8];
        for (int i = 0; i < 8; i++) begin
            r2s[i] = $urandom;
            disp(5'(i), 32'd0, r2s[i], 1'b1, 4'd1, 1'b0, 4'd0, 4'(i));
            tick();
        end
        idle();
        tests_run++;
        if ({bus.full, bus.alu_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL full_set: full,alu_valid got %b expected 10", {bus.full, bus.alu_valid});
        end
        disp(5'h01, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
        tick();
        idle();
        tests_run++;
        if ({bus.dispatch_err, bus.full} !== 2'b11) begin
            tests_failed++;
            $display("FAIL full_overflow: err,full got %b expected 11", {bus.dispatch_err, bus.full});
        end
        bus.cdb_alu_ready  = 1'b1;
        bus.cdb_alu_rob_id = 4'd1;
        bus.cdb_alu_value  = 32'habc;
        tick();
        idle();
        tests_run++;
        if ({bus.full, bus.alu_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL full_wake: full,alu_valid got %b expected 10", {bus.full, bus.alu_valid});
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            tests_run++;
            if (obs() !== exp_issue(5'(k), 32'habc, r2s[k], 4'(k))) begin
                tests_failed++;
                $display("FAIL full_drain_%0d: got %h expected %h", k, obs(), exp_issue(5'(k), 32'habc, r2s[k], 4'(k)));
            end
            if (k == 0) begin
                tests_run++;
                if (bus.full !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL full_release: full got %b expected 0", bus.full);
                end
            end
        end
        tick();
        tests_run++;
        if (bus.alu_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_dropped: alu_valid got %b expected 0 (rob %0d)", bus.alu_valid, bus.alu_rob_id);
        end
        $display("[TB] full: 8 entries drained in dispatch order");
    endtask

    task automatic test_flush();
        for (int i = 0; i < 7; i++) begin
            disp(5'h02, 32'(i), 32'd0, 1'b1, 4'd4, 1'b0, 4'd0, 4'(i));
            tick();
        end
        disp(5'h03, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
        tick();
        idle();
        tests_run++;
        if ({bus.full, bus.alu_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL flush_pre: full,alu_valid got %b expected 10", {bus.full, bus.alu_valid});
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests_run++;
        if ({bus.full, bus.alu_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush_clear: full,alu_valid got %b expected 00", {bus.full, bus.alu_valid});
        end
        bus.cdb_alu_ready  = 1'b1;
        bus.cdb_alu_rob_id = 4'd4;
        bus.cdb_alu_value  = 32'h44;
        tick();
        idle();
        for (int c = 0; c < 4; c++) begin
            tick();
            tests_run++;
            if (bus.alu_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_no_issue: cycle %0d alu_valid got %b expected 0", c, bus.alu_valid);
            end
        end
        $display("[TB] flush dropped 8 entries");
    endtask

    task automatic test_stall();
        disp(5'h03, 32'd0, 32'h2, 1'b1, 4'd9, 1'b0, 4'd0, 4'd11);
        tick();
        disp(5'h01, 32'h30, 32'h40, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10);
        tick();
        idle();
        tests_run++;
        if (bus.alu_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_pre: alu_valid got %b expected 0", bus.alu_valid);
        end
        rdy_in = 1'b0;
        bus.cdb_alu_ready  = 1'b1;
        bus.cdb_alu_rob_id = 4'd9;
        bus.cdb_alu_value  = 32'h55;
        disp(5'h00, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12);
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (bus.alu_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold: cycle %0d alu_valid got %b expected 0", c, bus.alu_valid);
            end
        end
        idle();
        rdy_in = 1'b1;
        tick();
        tests_run++;
        if (obs() !== exp_issue(5'h01, 32'h30, 32'h40, 4'd10)) begin
            tests_failed++;
            $display("FAIL stall_resume: got %h expected %h", obs(), exp_issue(5'h01, 32'h30, 32'h40, 4'd10));
        end
        rdy_in = 1'b0;
        tick();
        tests_run++;
        if (obs() !== exp_issue(5'h01, 32'h30, 32'h40, 4'd10)) begin
            tests_failed++;
            $display("FAIL stall_out_hold: got %h expected %h", obs(), exp_issue(5'h01, 32'h30, 32'h40, 4'd10));
        end
        rdy_in = 1'b1;
        tick();
        tests_run++;
        if (bus.alu_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_no_wake: alu_valid got %b expected 0 (rob %0d)", bus.alu_valid, bus.alu_rob_id);
        end
        bus.cdb_alu_ready  = 1'b1;
        bus.cdb_alu_rob_id = 4'd9;
        bus.cdb_alu_value  = 32'h66;
        tick();
        idle();
        tick();
        tests_run++;
        if (obs() !== exp_issue(5'h03, 32'h66, 32'h2, 4'd11)) begin
            tests_failed++;
            $display("FAIL stall_late_wake: got %h expected %h", obs(), exp_issue(5'h03, 32'h66, 32'h2, 4'd11));
        end
        tick();
        tests_run++;
        if (bus.alu_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_dropped_dispatch: alu_valid got %b expected 0", bus.alu_valid);
        end
        $display("[TB] stall: rob=10 and rob=11 issued after rdy_in returned");
    endtask

    task automatic test_back_to_back();
        disp(5'h00, 32'd2, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
        tick();
        disp(5'h00, 32'd0, 32'd10, 1'b1, 4'd1, 1'b0, 4'd0, 4'd2);
        tick();
        idle();
        tests_run++;
        if (obs() !== exp_issue(5'h00, 32'd2, 32'd3, 4'd1)) begin
            tests_failed++;
            $display("FAIL b2b_producer: got %h expected %h", obs(), exp_issue(5'h00, 32'd2, 32'd3, 4'd1));
        end
        bus.cdb_alu_ready  = 1'b1;
        bus.cdb_alu_rob_id = 4'd1;
        bus.cdb_alu_value  = 32'd5;
        tick();
        idle();
        tests_run++;
        if (bus.alu_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_gap: alu_valid got %b expected 0", bus.alu_valid);
        end
        tick();
        tests_run++;
        if (obs() !== exp_issue(5'h00, 32'd5, 32'd10, 4'd2)) begin
            tests_failed++;
            $display("FAIL b2b_consumer: got %h expected %h", obs(), exp_issue(5'h00, 32'd5, 32'd10, 4'd2));
        end
        $display("[TB] back-to-back rob=1 -> rob=2");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) begin
            disp(5'h04, 32'd0, 32'(i), 1'b1, 4'd12, 1'b0, 4'd0, 4'(i));
            tick();
        end
        idle();
        bus.cdb_mem_ready  = 1'b1;
        bus.cdb_mem_rob_id = 4'd12;
        bus.cdb_mem_value  = 32'h99;
        tick();
        idle();
        tick();
        tests_run++;
        if (bus.alu_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_pre: alu_valid got %b expected 1", bus.alu_valid);
        end
        #3 rst_in = 1'b1;
        #1;
        tests_run++;
        if ({obs(), bus.full} !== 75'd0) begin
            tests_failed++;
            $display("FAIL areset_immediate: got %h expected 0", {obs(), bus.full});
        end
        tick();
        rst_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (bus.alu_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL areset_dropped: cycle %0d alu_valid got %b expected 0", c, bus.alu_valid);
            end
        end
        $display("[TB] async reset dropped 7 woken entries");
    endtask

    task automatic test_random();
        bit          p_disp = 1'b0;
        logic [4:0]  p_type = '0;
        logic [31:0] p_r1 = '0, p_r2 = '0;
        bit          p_hd1 = 1'b0, p_hd2 = 1'b0;
        logic [3:0]  p_d1 = '0, p_d2 = '0, p_rob = '0;
        bit          pa_rdy = 1'b0, pm_rdy = 1'b0;
        logic [3:0]  pa_tag = '0, pm_tag = '0;
        logic [31:0] pa_val = '0, pm_val = '0;
        int          count = 0;
        int          issued = 0;
        bit          any_ready;
        int          r;

        do_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;

        for (int cyc = 0; cyc < 1000; cyc++) begin
            tick();
            any_ready = 1'b0;
            for (int i = 0; i < 16; i++)
                if (m_valid[i] && !m_hd1[i] && !m_hd2[i]) any_ready = 1'b1;
            if (bus.alu_valid === 1'b1) begin
                r = int'(bus.alu_rob_id);
                tests_run++;
                if (!(m_valid[r] && !m_hd1[r] && !m_hd2[r])) begin
                    tests_failed++;
                    $display("FAIL rand_issue_unexpected: cycle %0d rob %0d issued but not ready", cyc, r);
                end else begin
                    tests_run++;
                    if (obs() !== exp_issue(m_type[r], m_v1[r], m_v2[r], 4'(r))) begin
                        tests_failed++;
                        $display("FAIL rand_issue_data: cycle %0d got %h expected %h", cyc, obs(), exp_issue(m_type[r], m_v1[r], m_v2[r], 4'(r)));
                    end
                    $display("[TB] rand issue rob=%0d type=%h r1=%h r2=%h", r, bus.alu_type, bus.alu_r1, bus.alu_r2);
                    m_valid[r] = 1'b0;
                    count--;
                    issued++;
                end
            end else begin
                tests_run++;
                if (any_ready) begin
                    tests_failed++;
                    $display("FAIL rand_no_issue: cycle %0d alu_valid got 0 expected 1 (op ready)", cyc);
                end
            end

            // apply what the DUT sampled at this edge: dispatch, then CDB snoop
            if (p_disp) begin
                m_valid[p_rob] = 1'b1;
                m_type[p_rob]  = p_type;
                m_v1[p_rob] = p_r1;  m_hd1[p_rob] = p_hd1;  m_d1[p_rob] = p_d1;
                m_v2[p_rob] = p_r2;  m_hd2[p_rob] = p_hd2;  m_d2[p_rob] = p_d2;
                count++;
            end
            for (int i = 0; i < 16; i++) begin
                if (m_valid[i] && m_hd1[i]) begin
                    if (pa_rdy && pa_tag == m_d1[i])      begin m_v1[i] = pa_val; m_hd1[i] = 1'b0; end
                    else if (pm_rdy && pm_tag == m_d1[i]) begin m_v1[i] = pm_val; m_hd1[i] = 1'b0; end
                end
                if (m_valid[i] && m_hd2[i]) begin
                    if (pa_rdy && pa_tag == m_d2[i])      begin m_v2[i] = pa_val; m_hd2[i] = 1'b0; end
                    else if (pm_rdy && pm_tag == m_d2[i]) begin m_v2[i] = pm_val; m_hd2[i] = 1'b0; end
                end
            end

            tests_run++;
            if (bus.full !== (count == 8)) begin
                tests_failed++;
                $display("FAIL rand_full: cycle %0d got %b expected %b", cyc, bus.full, (count == 8));
            end

            if (cyc >= 400 && count == 0) break;

            idle();
            p_disp = (cyc < 400) && (count < 8) && ($urandom_range(0, 3) != 0);
            if (p_disp) begin
                int s = $urandom_range(0, 15);
                for (int k = 0; k < 16; k++) begin
                    if (!m_valid[(s + k) % 16]) begin
                        p_rob = 4'((s + k) % 16);
                        break;
                    end
                end
                p_type = 5'($urandom);
                p_r1 = $urandom;  p_r2 = $urandom;
                p_hd1 = ($urandom_range(0, 1) == 1);  p_d1 = 4'($urandom);
                p_hd2 = ($urandom_range(0, 2) == 0);  p_d2 = 4'($urandom);
                disp(p_type, p_r1, p_r2, p_hd1, p_d1, p_hd2, p_d2, p_rob);
            end
            pa_rdy = ($urandom_range(0, 1) == 1);  pa_tag = 4'($urandom);  pa_val = $urandom;
            pm_rdy = ($urandom_range(0, 1) == 1);  pm_tag = 4'($urandom);  pm_val = $urandom;
            bus.cdb_alu_ready = pa_rdy;  bus.cdb_alu_rob_id = pa_tag;  bus.cdb_alu_value = pa_val;
            bus.cdb_mem_ready = pm_rdy;  bus.cdb_mem_rob_id = pm_tag;  bus.cdb_mem_value = pm_val;
        end
        idle();
        tests_run++;
        if (count != 0) begin
            tests_failed++;
            $display("FAIL rand_drain: %0d ops left, required 0", count);
        end
        $display("[TB] random run issued %0d ops", issued);
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_full();
        test_flush();
        test_stall();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
